fp_align_add: RTL and testbench

- Single-precision add/sub front end that sits directly upstream of normalize_mantissa.
- Accepts two IEEE-754 operands and an op bit, then swaps them so the larger magnitude comes first.
- Aligns the smaller mantissa with a multi-cycle right shifter, adds or subtracts, and emits M_result, M_carry, what_to_do, exponent and sign for normalisation.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/fp_align_add.sv | 133 +++++++++++++
 tb/tb_fp_align_add.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_add.sv
// Single-precision add/sub front end: swaps by magnitude, aligns the smaller mantissa, adds/subtracts.
// Optional FP_ALIGN_BARREL_EN replaces the iterative aligner with a one-cycle barrel shift.
module fp_align_add #(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] M_result,
  output logic        M_carry,
  output logic        what_to_do,
  output logic [7:0]  exp_out,
  output logic        sign_out
);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t      state, state_nxt;
  logic [23:0] ml, ms;
  logic [7:0]  exp_l;
  logic        sign_l, sub_r;
  logic [4:0]  remaining;

  logic        bs, a_hid, b_hid, b_big;
  logic [7:0]  a_exp, b_exp, exp_l_c, exp_s_c, d_c;
  logic [23:0] a_man, b_man, man_l_c, man_s_c;
  logic        sign_l_c, sign_s_c;
  logic [24:0] sum_c;

  // Operand classification and swap, evaluated against the live inputs at accept.
  always_comb begin
    bs      = b[31] ^ op_sub;
    a_hid   = |a[30:23];
    b_hid   = |b[30:23];
    a_exp   = a_hid ? a[30:23] : 8'd1;
    b_exp   = b_hid ? b[30:23] : 8'd1;
    a_man   = {a_hid, a[22:0]};
    b_man   = {b_hid, b[22:0]};
    b_big   = {b_exp, b_man} > {a_exp, a_man};
    exp_l_c  = b_big ? b_exp : a_exp;
    exp_s_c  = b_big ? a_exp : b_exp;
    man_l_c  = b_big ? b_man : a_man;
    man_s_c  = b_big ? a_man : b_man;
    sign_l_c = b_big ? bs : a[31];
    sign_s_c = b_big ? a[31] : bs;
    d_c      = exp_l_c - exp_s_c;
  end

`ifndef FP_ALIGN_BARREL_EN
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  logic [4:0] shamt;
  assign shamt = (remaining > STEP) ? STEP : remaining;
`endif

  // Subtraction cannot go negative because L is the larger magnitude.
  assign sum_c = sub_r ? ({1'b0, ml} - {1'b0, ms}) : ({1'b0, ml} + {1'b0, ms});

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ALIGN;
      end
`ifdef FP_ALIGN_BARREL_EN
      ALIGN: state_nxt = ADD;
`else
      ALIGN: if (remaining == 5'd0) state_nxt = ADD;
`endif
      ADD: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ml         <= '0;
      ms         <= '0;
      exp_l      <= '0;
      sign_l     <= 1'b0;
      sub_r      <= 1'b0;
      remaining  <= '0;
      M_result   <= '0;
      M_carry    <= 1'b0;
      what_to_do <= 1'b0;
      exp_out    <= '0;
      sign_out   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          ml        <= man_l_c;
          ms        <= (d_c >= 8'd24) ? 24'd0 : man_s_c;
          remaining <= (d_c >= 8'd24) ? 5'd24 : d_c[4:0];
          exp_l     <= exp_l_c;
          sign_l    <= sign_l_c;
          sub_r     <= sign_l_c ^ sign_s_c;
        end
        ALIGN: if (remaining != 5'd0) begin
`ifdef FP_ALIGN_BARREL_EN
          ms        <= ms >> remaining;
          remaining <= 5'd0;
`else
          ms        <= ms >> shamt;
          remaining <= remaining - shamt;
`endif
        end
        ADD: begin
          M_result   <= sum_c[23:0];
          M_carry    <= sub_r ? 1'b0 : sum_c[24];
          what_to_do <= sub_r;
          exp_out    <= exp_l;
          sign_out   <= (sum_c == 25'd0) ? 1'b0 : sign_l;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_add.sv
// Randomized bench for fp_align_add: two instances (SHIFT_STEP 1 and 8) share stimulus and are
// compared against an integer-arithmetic reference model, plus directed cases and reset/backpressure.
module tb_fp_align_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, op_sub, out_ready;
  logic [31:0] a, b;

  logic        in_ready1, out_valid1, carry1, wtd1, sign1;
  logic [23:0] res1;
  logic [7:0]  exp1;
  logic        in_ready8, out_valid8, carry8, wtd8, sign8;
  logic [23:0] res8;
  logic [7:0]  exp8;

  fp_align_add #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .M_result(res1),
    .M_carry(carry1), .what_to_do(wtd1), .exp_out(exp1), .sign_out(sign1)
  );

  fp_align_add #(.SHIFT_STEP(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready), .M_result(res8),
    .M_carry(carry8), .what_to_do(wtd8), .exp_out(exp8), .sign_out(sign8)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference results for the current operation
  logic [23:0] m_r;
  logic        m_c, m_w, m_s;
  logic [7:0]  m_e;
  int          m_d;

  task automatic model(input logic [31:0] x, input logic [31:0] y, input logic o);
    longint ex, ey, mx, my, el, es, ml, msm, res;
    logic   sx, sy, sl, ss;
    ex = (x[30:23] == 8'd0) ? 64'd1 : longint'(x[30:23]);
    ey = (y[30:23] == 8'd0) ? 64'd1 : longint'(y[30:23]);
    mx = longint'(x[22:0]) + ((x[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    my = longint'(y[22:0]) + ((y[30:23] != 8'd0) ? 64'd8388608 : 64'd0);
    sx = x[31];
    sy = y[31] ^ o;
    if (ey * 16777216 + my > ex * 16777216 + mx) begin
      el = ey; ml = my; sl = sy; es = ex; msm = mx; ss = sx;
    end else begin
      el = ex; ml = mx; sl = sx; es = ey; msm = my; ss = sy;
    end
    m_d = int'(el - es);
    msm = (m_d >= 24) ? 64'd0 : msm / (64'd1 << m_d);
    m_w = sl ^ ss;
    res = m_w ? (ml - msm) : (ml + msm);
    m_r = 24'(res);
    m_c = (res >= 64'd16777216);
    m_e = 8'(el);
    m_s = (res == 64'd0) ? 1'b0 : sl;
  endtask

  function automatic int exp_lat(input int d, input int stepw);
`ifdef FP_ALIGN_BARREL_EN
    return 2 + 0 * (d + stepw);
`else
    int dd;
    dd = (d > 24) ? 24 : d;
    return (dd + stepw - 1) / stepw + 2;
`endif
  endfunction

  task automatic chk_out();
    chk("res1", 32'(res1), 32'(m_r));
    chk("carry1", 32'(carry1), 32'(m_c));
    chk("wtd1", 32'(wtd1), 32'(m_w));
    chk("exp1", 32'(exp1), 32'(m_e));
    chk("sign1", 32'(sign1), 32'(m_s));
    chk("res8", 32'(res8), 32'(m_r));
    chk("carry8", 32'(carry8), 32'(m_c));
    chk("wtd8", 32'(wtd8), 32'(m_w));
    chk("exp8", 32'(exp8), 32'(m_e));
    chk("sign8", 32'(sign8), 32'(m_s));
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb2, input logic top, input int hold);
    int lat1, lat8, cyc;
    model(ta, tb2, top);
    chk("in_ready1_idle", 32'(in_ready1), 32'd1);
    chk("in_ready8_idle", 32'(in_ready8), 32'd1);
    a = ta; b = tb2; op_sub = top; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op_sub = 1'($urandom);
    lat1 = -1; lat8 = -1; cyc = 0;
    while ((lat1 < 0 || lat8 < 0) && cyc < 40) begin
      step();
      cyc++;
      if (out_valid1 && lat1 < 0) begin
        lat1 = cyc;
        chk("in_ready1_busy", 32'(in_ready1), 32'd0);
      end
      if (out_valid8 && lat8 < 0) begin
        lat8 = cyc;
        chk("in_ready8_busy", 32'(in_ready8), 32'd0);
      end
    end
    chk("latency1", 32'(lat1), 32'(exp_lat(m_d, 1)));
    chk("latency8", 32'(lat8), 32'(exp_lat(m_d, 8)));
    chk_out();
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_vld1", 32'(out_valid1), 32'd1);
      chk("hold_rdy1", 32'(in_ready1), 32'd0);
      chk("hold_vld8", 32'(out_valid8), 32'd1);
      chk("hold_rdy8", 32'(in_ready8), 32'd0);
      chk_out();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_vld1", 32'(out_valid1), 32'd0);
    chk("release_rdy1", 32'(in_ready1), 32'd1);
    chk("release_vld8", 32'(out_valid8), 32'd0);
    chk("release_rdy8", 32'(in_ready8), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int seen, e, mode;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    step();
    step();
    chk("rst_in_ready1", 32'(in_ready1), 32'd1);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    chk("rst_res1", 32'(res1), 32'd0);
    chk("rst_carry1", 32'(carry1), 32'd0);
    chk("rst_wtd1", 32'(wtd1), 32'd0);
    chk("rst_exp1", 32'(exp1), 32'd0);
    chk("rst_sign1", 32'(sign1), 32'd0);
    chk("rst_in_ready8", 32'(in_ready8), 32'd1);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed cases with hand-derived results
    run_op(32'h3F800000, 32'h3F800000, 1'b0, 0);
    chk("one_plus_one_res", 32'(res1), 32'h0);
    chk("one_plus_one_carry", 32'(carry1), 32'd1);
    run_op(32'h3F800000, 32'h3F800000, 1'b1, 0);
    chk("one_minus_one_wtd", 32'(wtd1), 32'd1);
    chk("one_minus_one_sign", 32'(sign1), 32'd0);
    chk("one_minus_one_exp", 32'(exp1), 32'd127);
    run_op(32'h3FC00000, 32'h3E800000, 1'b0, 5);
    chk("d2_res", 32'(res1), 32'hE00000);
    run_op(32'h3E800000, 32'h3FC00000, 1'b1, 0);
    chk("swap_res", 32'(res1), 32'hA00000);
    chk("swap_sign", 32'(sign1), 32'd1);
    run_op(32'h4B800000, 32'h3F800000, 1'b0, 0);
    chk("clamp_res", 32'(res1), 32'h800000);
    chk("clamp_exp", 32'(exp1), 32'd151);

    // Reset right after accept (operation is in ALIGN) must drop it
    a = 32'h4B800000; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_vld1", 32'(out_valid1), 32'd0);
    chk("midrst_rdy1", 32'(in_ready1), 32'd1);
    chk("midrst_res1", 32'(res1), 32'd0);
    chk("midrst_vld8", 32'(out_valid8), 32'd0);
    chk("midrst_rdy8", 32'(in_ready8), 32'd1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (out_valid1 || out_valid8) seen++;
    end
    chk("midrst_no_emit", 32'(seen), 32'd0);

    // Randomized operands, biased towards close exponents, denormals and cancellation
    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) rb = $urandom;
      else if (mode == 1) begin
        e = int'(ra[30:23]) + int'($urandom_range(0, 60)) - 30;
        if (e < 0) e = 0;
        if (e > 255) e = 255;
        rb = {1'($urandom), 8'(e), 23'($urandom)};
      end else if (mode == 2) rb = ra ^ {1'($urandom), 31'd0};
      else begin
        ra = {1'($urandom), 8'd0, 23'($urandom)};
        rb = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
      end
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
